// File: rtl/divider_arbiter.sv
// divider_arbiter: shares one sequential divider among N requesters.
// Round-robin selection in IDLE, one-cycle LAUNCH (grant + start), WAIT for
// the divider's done pulse (bounded by TIMEOUT), then RESP holds the result
// for the winner until it acknowledges. Divide-by-zero never reaches the
// divider: it is answered directly from LAUNCH.
module divider_arbiter #(
  parameter int N       = 4,
  parameter int WIDTH   = 24,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         req_sign,
  input  logic [N*WIDTH-1:0]   req_dividend,
  input  logic [N*WIDTH-1:0]   req_divisor,
  output logic [N-1:0]         grant,
  output logic [N-1:0]         resp_valid,
  input  logic [N-1:0]         resp_ack,
  output logic [WIDTH-1:0]     resp_quotient,
  output logic [WIDTH-1:0]     resp_remainder,
  output logic                 resp_dbz,
  output logic                 resp_err,
  output logic                 busy,
  output logic                 div_start,
  output logic                 div_sign,
  output logic [WIDTH-1:0]     div_dividend,
  output logic [WIDTH-1:0]     div_divisor,
  input  logic [WIDTH-1:0]     div_quotient,
  input  logic [WIDTH-1:0]     div_remainder,
  input  logic                 div_ready
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [PW-1:0]    ptr_reg, ptr_next;
  logic [PW-1:0]    w_reg, w_next;
  logic             dbz_reg, dbz_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             sign_reg, sign_next;
  logic [WIDTH-1:0] dividend_reg, dividend_next;
  logic [WIDTH-1:0] divisor_reg, divisor_next;
  logic [WIDTH-1:0] quo_reg, quo_next;
  logic [WIDTH-1:0] rem_reg, rem_next;
  logic             resp_dbz_reg, resp_dbz_next;
  logic             resp_err_reg, resp_err_next;

  // Per-requester operand views of the flattened buses
  logic [WIDTH-1:0] dvd_arr [N];
  logic [WIDTH-1:0] dvs_arr [N];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_unpack
      assign dvd_arr[gi] = req_dividend[gi*WIDTH +: WIDTH];
      assign dvs_arr[gi] = req_divisor[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Round-robin pick: rotate req so bit 0 is the requester at ptr, take the
  // lowest set bit, then rotate the offset back into a requester index.
  logic [N-1:0]  req_rot;
  logic [PW-1:0] rot_off;
  logic [PW:0]   pick_sum;
  logic [PW-1:0] pick;
  logic [PW-1:0] w_inc;
  logic [N-1:0]  w_onehot;

  assign req_rot  = (req >> ptr_reg) | (req << (N - int'(ptr_reg)));
  assign pick_sum = {1'b0, ptr_reg} + {1'b0, rot_off};
  assign pick     = (pick_sum >= (PW+1)'(N)) ? PW'(pick_sum - (PW+1)'(N))
                                             : pick_sum[PW-1:0];
  assign w_inc    = (w_reg == PW'(N-1)) ? '0 : w_reg + PW'(1);
  assign w_onehot = N'(1) << w_reg;

  // Lowest set bit of the rotated request vector
  always_comb begin
    rot_off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_rot[i]) rot_off = PW'(i);
    end
  end

  // Next-state and output decode
  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    w_next        = w_reg;
    dbz_next      = dbz_reg;
    cnt_next      = cnt_reg;
    sign_next     = sign_reg;
    dividend_next = dividend_reg;
    divisor_next  = divisor_reg;
    quo_next      = quo_reg;
    rem_next      = rem_reg;
    resp_dbz_next = resp_dbz_reg;
    resp_err_next = resp_err_reg;
    grant         = '0;
    resp_valid    = '0;
    div_start     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (|req) begin
          w_next        = pick;
          sign_next     = req_sign[pick];
          dividend_next = dvd_arr[pick];
          divisor_next  = dvs_arr[pick];
          dbz_next      = (dvs_arr[pick] == '0);
          state_next    = LAUNCH;
        end
      end

      LAUNCH: begin
        grant    = w_onehot;
        ptr_next = w_inc;
        if (dbz_reg) begin
          // Answer divide-by-zero locally; the divider is never started.
          quo_next      = '1;
          rem_next      = dividend_reg;
          resp_dbz_next = 1'b1;
          resp_err_next = 1'b0;
          state_next    = RESP;
        end else begin
          div_start  = 1'b1;
          cnt_next   = '0;
          state_next = WAIT;
        end
      end

      WAIT: begin
        cnt_next = cnt_reg + CW'(1);
        if (div_ready) begin
          // A done pulse beats a timeout landing in the same cycle.
          quo_next      = div_quotient;
          rem_next      = div_remainder;
          resp_dbz_next = 1'b0;
          resp_err_next = 1'b0;
          state_next    = RESP;
        end else if (cnt_reg == CW'(TIMEOUT - 1)) begin
          quo_next      = '0;
          rem_next      = '0;
          resp_dbz_next = 1'b0;
          resp_err_next = 1'b1;
          state_next    = RESP;
        end
      end

      RESP: begin
        resp_valid = w_onehot;
        if (|(resp_ack & w_onehot)) begin
          resp_dbz_next = 1'b0;
          resp_err_next = 1'b0;
          state_next    = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      ptr_reg      <= '0;
      w_reg        <= '0;
      dbz_reg      <= 1'b0;
      cnt_reg      <= '0;
      sign_reg     <= 1'b0;
      dividend_reg <= '0;
      divisor_reg  <= '0;
      quo_reg      <= '0;
      rem_reg      <= '0;
      resp_dbz_reg <= 1'b0;
      resp_err_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      w_reg        <= w_next;
      dbz_reg      <= dbz_next;
      cnt_reg      <= cnt_next;
      sign_reg     <= sign_next;
      dividend_reg <= dividend_next;
      divisor_reg  <= divisor_next;
      quo_reg      <= quo_next;
      rem_reg      <= rem_next;
      resp_dbz_reg <= resp_dbz_next;
      resp_err_reg <= resp_err_next;
    end
  end

  assign busy           = (state_reg != IDLE);
  assign div_sign       = sign_reg;
  assign div_dividend   = dividend_reg;
  assign div_divisor    = divisor_reg;
  assign resp_quotient  = quo_reg;
  assign resp_remainder = rem_reg;
  assign resp_dbz       = resp_dbz_reg;
  assign resp_err       = resp_err_reg;

endmodule

// File: tb/tb_divider_arbiter.sv
// Testbench for divider_arbiter with a behavioural divider model and a
// round-robin reference model.
module tb_divider_arbiter;
  localparam int N  = 4;
  localparam int W  = 24;
  localparam int TO = 64;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N-1:0]   req_sign = '0;
  logic [N*W-1:0] req_dividend = '0;
  logic [N*W-1:0] req_divisor = '0;
  logic [N-1:0]   grant;
  logic [N-1:0]   resp_valid;
  logic [N-1:0]   resp_ack = '0;
  logic [W-1:0]   resp_quotient, resp_remainder;
  logic           resp_dbz, resp_err, busy;
  logic           div_start, div_sign;
  logic [W-1:0]   div_dividend, div_divisor;
  logic [W-1:0]   div_quotient, div_remainder;
  logic           div_ready;

  int checks = 0;
  int errors = 0;
  int mptr = 0;

  logic [W-1:0] op_a [N];
  logic [W-1:0] op_b [N];
  logic         op_s [N];

  always #5 clk = ~clk;

  divider_arbiter #(.N(N), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_sign(req_sign),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .grant(grant), .resp_valid(resp_valid), .resp_ack(resp_ack),
    .resp_quotient(resp_quotient), .resp_remainder(resp_remainder),
    .resp_dbz(resp_dbz), .resp_err(resp_err), .busy(busy),
    .div_start(div_start), .div_sign(div_sign),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .div_remainder(div_remainder),
    .div_ready(div_ready)
  );

  // Reference arithmetic: {quotient, remainder}; zero divisor gives all-ones / dividend
  function automatic logic [2*W-1:0] ref_div(input logic sgn, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    longint sa, sb;
    logic [W-1:0] q, r;
    if (b == '0) begin
      q = '1;
      r = a;
    end else if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = W'(sa / sb);
      r = W'(sa % sb);
    end else begin
      sa = longint'(a);
      sb = longint'(b);
      q = W'(sa / sb);
      r = W'(sa % sb);
    end
    return {q, r};
  endfunction

  // Round-robin reference: first requester at or after p, wrapping
  function automatic int exp_winner(input logic [N-1:0] rq, input int p);
    for (int i = 0; i < N; i++) begin
      if (rq[(p + i) % N]) return (p + i) % N;
    end
    return -1;
  endfunction

  // Divider model: result from the operands it is handed, done pulse W+1 cycles after start
  bit             model_en = 1'b1;
  logic           inject = 1'b0;
  logic           m_ready = 1'b0;
  logic [2*W-1:0] m_qr = '0;
  bit             m_pend = 1'b0;
  int             m_cnt = 0;

  assign div_ready     = m_ready | inject;
  assign div_quotient  = m_qr[2*W-1:W];
  assign div_remainder = m_qr[W-1:0];

  always @(posedge clk) begin
    m_ready <= 1'b0;
    if (div_start && model_en) begin
      m_qr   <= ref_div(div_sign, div_dividend, div_divisor);
      m_pend <= 1'b1;
      m_cnt  <= 0;
    end else if (m_pend) begin
      if (m_cnt + 1 == W) begin
        m_ready <= 1'b1;
        m_pend  <= 1'b0;
      end
      m_cnt <= m_cnt + 1;
    end
  end

  typedef struct packed {
    int gidx; int glat; int gcount; int rlat;
    logic start; logic sign;
    logic [W-1:0] dvd; logic [W-1:0] dvs;
    logic [W-1:0] q; logic [W-1:0] r; logic [W-1:0] q2; logic [W-1:0] r2;
    logic [N-1:0] vmask; logic [N-1:0] vmask2; logic [N-1:0] vafter;
    logic dbz; logic err; logic err2; logic dbz_after; logic err_after; logic to;
  } job_t;

  task automatic set_op(input int i, input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    op_s[i] = s; op_a[i] = a; op_b[i] = b;
    req_sign[i] = s;
    req_dividend[i*W +: W] = a;
    req_divisor[i*W +: W] = b;
  endtask

  // Drives one job from an IDLE negedge and records what the DUT did
  task automatic run_job(input logic [N-1:0] rq, input bit hold, input bit stale, output job_t o);
    bit done;
    o = '0;
    o.gidx = -1;
    done = 1'b0;
    req = rq;
    for (int k = 1; k <= 200 && !done; k++) begin
      @(negedge clk);
      if (grant != '0) begin
        o.gcount = o.gcount + 1;
        if (o.gcount == 1) begin
          for (int i = 0; i < N; i++) if (grant[i]) o.gidx = i;
          o.glat = k; o.start = div_start; o.sign = div_sign;
          o.dvd = div_dividend; o.dvs = div_divisor;
          if (!hold) req[o.gidx] = 1'b0;
        end
      end
      if (resp_valid != '0) begin
        o.rlat = k; o.vmask = resp_valid;
        o.q = resp_quotient; o.r = resp_remainder; o.dbz = resp_dbz; o.err = resp_err;
        if (stale) begin
          inject = 1'b1;
          resp_ack = ~resp_valid;
          @(negedge clk);
          inject = 1'b0;
          resp_ack = '0;
        end
        o.vmask2 = resp_valid; o.q2 = resp_quotient; o.r2 = resp_remainder; o.err2 = resp_err;
        resp_ack = resp_valid;
        @(negedge clk);
        resp_ack = '0;
        o.vafter = resp_valid; o.dbz_after = resp_dbz; o.err_after = resp_err;
        done = 1'b1;
      end
    end
    o.to = !done;
    $display("job req=%b grant=%0d glat=%0d rlat=%0d q=%h r=%h dbz=%b err=%b",
             rq, o.gidx, o.glat, o.rlat, o.q, o.r, o.dbz, o.err);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; resp_ack = '0; inject = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mptr = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0; resp_ack = '0;
    for (int i = 0; i < N; i++) set_op(i, 1'b1, W'(i * 77 + 3), W'(i + 5));
    repeat (3) @(negedge clk);
    checks++; if (grant !== '0 || resp_valid !== '0) begin errors++;
      $display("FAIL reset_handshake: grant=%b resp_valid=%b want 0", grant, resp_valid); end
    checks++; if (busy !== 1'b0 || div_start !== 1'b0) begin errors++;
      $display("FAIL reset_busy: busy=%b div_start=%b want 0", busy, div_start); end
    checks++; if ({div_sign, div_dividend, div_divisor} !== '0) begin errors++;
      $display("FAIL reset_div_ops: sign=%b dvd=%h dvs=%h want 0", div_sign, div_dividend, div_divisor); end
    checks++; if ({resp_quotient, resp_remainder, resp_dbz, resp_err} !== '0) begin errors++;
      $display("FAIL reset_resp: q=%h r=%h dbz=%b err=%b want 0", resp_quotient, resp_remainder, resp_dbz, resp_err); end
    rst_n = 1'b1;
    mptr = 0;
    @(negedge clk);
  endtask

  task automatic test_single();
    job_t o;
    set_op(2, 1'b0, W'(100), W'(7));
    run_job(4'b0100, 1'b0, 1'b0, o);
    checks++; if (o.to !== 1'b0) begin errors++; $display("FAIL single_timeout: no response within budget"); end
    checks++; if (o.gidx !== 2 || o.glat !== 1 || o.gcount !== 1) begin errors++;
      $display("FAIL single_grant: idx=%0d lat=%0d pulses=%0d want 2/1/1", o.gidx, o.glat, o.gcount); end
    checks++; if (o.start !== 1'b1 || o.dvd !== W'(100) || o.dvs !== W'(7) || o.sign !== 1'b0) begin errors++;
      $display("FAIL single_launch: start=%b dvd=%h dvs=%h sign=%b", o.start, o.dvd, o.dvs, o.sign); end
    checks++; if (o.rlat !== W + 3 || o.vmask !== 4'b0100) begin errors++;
      $display("FAIL single_resp_timing: lat=%0d valid=%b want %0d/0100", o.rlat, o.vmask, W + 3); end
    checks++; if (o.q !== W'(14) || o.r !== W'(2) || o.dbz !== 1'b0 || o.err !== 1'b0) begin errors++;
      $display("FAIL single_result: q=%h r=%h dbz=%b err=%b want 14/2/0/0", o.q, o.r, o.dbz, o.err); end
    checks++; if (o.vafter !== '0) begin errors++;
      $display("FAIL single_clear: resp_valid=%b after ack want 0", o.vafter); end
    mptr = 3;
  endtask

  task automatic test_signed();
    job_t o;
    set_op(0, 1'b1, W'(-100), W'(7));
    run_job(4'b0001, 1'b0, 1'b0, o);
    checks++; if (o.gidx !== 0 || o.sign !== 1'b1 || o.rlat !== W + 3) begin errors++;
      $display("FAIL signed_launch: idx=%0d sign=%b lat=%0d", o.gidx, o.sign, o.rlat); end
    checks++; if (o.q !== 24'hFFFFF2 || o.r !== 24'hFFFFFE) begin errors++;
      $display("FAIL signed_result: q=%h r=%h want fffff2/fffffe", o.q, o.r); end
    mptr = 1;
  endtask

  task automatic test_dbz();
    job_t o;
    set_op(1, 1'b0, W'(55), W'(0));
    run_job(4'b0010, 1'b0, 1'b0, o);
    checks++; if (o.gidx !== 1 || o.start !== 1'b0) begin errors++;
      $display("FAIL dbz_launch: idx=%0d div_start=%b want 1/0", o.gidx, o.start); end
    checks++; if (o.rlat !== 2 || o.vmask !== 4'b0010) begin errors++;
      $display("FAIL dbz_timing: lat=%0d valid=%b want 2/0010", o.rlat, o.vmask); end
    checks++; if (o.q !== 24'hFFFFFF || o.r !== W'(55) || o.dbz !== 1'b1 || o.err !== 1'b0) begin errors++;
      $display("FAIL dbz_result: q=%h r=%h dbz=%b err=%b", o.q, o.r, o.dbz, o.err); end
    checks++; if (o.dbz_after !== 1'b0 || o.vafter !== '0) begin errors++;
      $display("FAIL dbz_clear: dbz=%b valid=%b after ack want 0", o.dbz_after, o.vafter); end
    mptr = 2;
  endtask

  task automatic test_round_robin();
    job_t o;
    int exp_order [5] = '{0, 1, 2, 3, 0};
    logic [2*W-1:0] e;
    do_reset();
    for (int i = 0; i < N; i++) set_op(i, 1'b0, W'(1000 * i + 5), W'(i + 3));
    for (int j = 0; j < 5; j++) begin
      run_job(4'b1111, 1'b1, 1'b0, o);
      e = ref_div(op_s[exp_order[j]], op_a[exp_order[j]], op_b[exp_order[j]]);
      checks++; if (o.gidx !== exp_order[j] || o.glat !== 1) begin errors++;
        $display("FAIL rr_order job %0d: idx=%0d lat=%0d want %0d/1", j, o.gidx, o.glat, exp_order[j]); end
      checks++; if ({o.q, o.r} !== e) begin errors++;
        $display("FAIL rr_result job %0d: q=%h r=%h want %h", j, o.q, o.r, e); end
    end
    run_job(4'b0001, 1'b0, 1'b0, o);
    checks++; if (o.gidx !== 0) begin errors++;
      $display("FAIL rr_wrap: idx=%0d want 0", o.gidx); end
    mptr = 1;
  endtask

  task automatic test_timeout();
    job_t o;
    model_en = 1'b0;
    set_op(3, 1'b0, W'(1000), W'(3));
    run_job(4'b1000, 1'b0, 1'b1, o);
    checks++; if (o.to !== 1'b0 || o.gidx !== 3 || o.start !== 1'b1) begin errors++;
      $display("FAIL timeout_launch: to=%b idx=%0d start=%b", o.to, o.gidx, o.start); end
    checks++; if (o.rlat !== TO + 2) begin errors++;
      $display("FAIL timeout_timing: lat=%0d want %0d", o.rlat, TO + 2); end
    checks++; if (o.err !== 1'b1 || o.q !== '0 || o.r !== '0 || o.dbz !== 1'b0) begin errors++;
      $display("FAIL timeout_result: err=%b q=%h r=%h dbz=%b want 1/0/0/0", o.err, o.q, o.r, o.dbz); end
    checks++; if (o.vmask2 !== 4'b1000 || o.err2 !== 1'b1 || o.q2 !== '0 || o.r2 !== '0) begin errors++;
      $display("FAIL timeout_stale_resp: valid=%b err=%b q=%h r=%h", o.vmask2, o.err2, o.q2, o.r2); end
    checks++; if (o.vafter !== '0 || o.err_after !== 1'b0) begin errors++;
      $display("FAIL timeout_clear: valid=%b err=%b want 0/0", o.vafter, o.err_after); end
    inject = 1'b1;
    @(negedge clk);
    inject = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || resp_valid !== '0) begin errors++;
      $display("FAIL timeout_stale_idle: busy=%b valid=%b want 0", busy, resp_valid); end
    model_en = 1'b1;
    mptr = 0;
  endtask

  task automatic test_reset_mid();
    job_t o;
    int bad;
    logic [2*W-1:0] e;
    set_op(1, 1'b0, W'(5000), W'(9));
    req = 4'b0010;
    @(negedge clk);
    checks++; if (grant !== 4'b0010) begin errors++;
      $display("FAIL midrst_grant: grant=%b want 0010", grant); end
    req = '0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || grant !== '0 || resp_valid !== '0 || div_start !== 1'b0) begin errors++;
      $display("FAIL midrst_ctrl: busy=%b grant=%b valid=%b start=%b want 0", busy, grant, resp_valid, div_start); end
    checks++; if (div_dividend !== '0 || div_divisor !== '0 || resp_quotient !== '0) begin errors++;
      $display("FAIL midrst_data: dvd=%h dvs=%h q=%h want 0", div_dividend, div_divisor, resp_quotient); end
    mptr = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (busy !== 1'b0 || resp_valid !== '0) bad++;
    end
    checks++; if (bad !== 0) begin errors++;
      $display("FAIL midrst_stale_pulse: %0d cycles busy/valid after reset, want 0", bad); end
    set_op(0, 1'b0, W'(81), W'(4));
    set_op(3, 1'b1, W'(-50), W'(6));
    run_job(4'b1001, 1'b0, 1'b0, o);
    e = ref_div(op_s[0], op_a[0], op_b[0]);
    checks++; if (o.gidx !== 0 || {o.q, o.r} !== e) begin errors++;
      $display("FAIL midrst_ptr: idx=%0d q=%h r=%h want 0 and %h", o.gidx, o.q, o.r, e); end
    run_job(4'b1000, 1'b0, 1'b0, o);
    e = ref_div(op_s[3], op_a[3], op_b[3]);
    checks++; if (o.gidx !== 3 || {o.q, o.r} !== e || o.rlat !== W + 3) begin errors++;
      $display("FAIL midrst_next: idx=%0d q=%h r=%h lat=%0d want 3 and %h", o.gidx, o.q, o.r, o.rlat, e); end
    mptr = 0;
  endtask

  task automatic test_random();
    job_t o;
    logic [N-1:0] pend;
    logic [2*W-1:0] e;
    int w, age [N], max_age;
    bit exp_dbz;
    pend = '0;
    max_age = 0;
    for (int i = 0; i < N; i++) age[i] = 0;
    for (int j = 0; j < 24; j++) begin
      pend = pend | N'($urandom_range(0, (1 << N) - 1));
      if (pend == '0) pend[$urandom_range(0, N - 1)] = 1'b1;
      for (int i = 0; i < N; i++)
        set_op(i, 1'($urandom_range(0, 1)), W'($urandom),
               ($urandom_range(0, 5) == 0) ? '0 :
               (($urandom_range(0, 1) == 0) ? W'($urandom_range(1, 300)) : W'($urandom)));
      w = exp_winner(pend, mptr);
      e = ref_div(op_s[w], op_a[w], op_b[w]);
      exp_dbz = (op_b[w] == '0);
      run_job(pend, 1'b0, 1'b0, o);
      checks++; if (o.to !== 1'b0 || o.gidx !== w || o.vmask !== N'(1 << w)) begin errors++;
        $display("FAIL rand_grant job %0d: idx=%0d valid=%b want %0d", j, o.gidx, o.vmask, w); end
      checks++; if ({o.q, o.r} !== e || o.dbz !== exp_dbz || o.err !== 1'b0) begin errors++;
        $display("FAIL rand_result job %0d: q=%h r=%h dbz=%b err=%b want %h dbz=%b", j, o.q, o.r, o.dbz, o.err, e, exp_dbz); end
      checks++; if (o.rlat !== (exp_dbz ? 2 : W + 3) || o.vafter !== '0) begin errors++;
        $display("FAIL rand_timing job %0d: lat=%0d after=%b", j, o.rlat, o.vafter); end
      for (int i = 0; i < N; i++) begin
        if (i == o.gidx) age[i] = 0;
        else if (pend[i]) age[i]++;
        if (age[i] > max_age) max_age = age[i];
      end
      pend[w] = 1'b0;
      mptr = (w + 1) % N;
    end
    checks++; if (max_age > N - 1) begin errors++;
      $display("FAIL rand_fairness: a request waited %0d jobs, limit %0d", max_age, N - 1); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_signed();
    test_dbz();
    test_round_robin();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/divider_arbiter.md
Name: divider_arbiter

Overview:
- Shares one sequential restoring divider among N requesters (display math, scaling, coordinate units).
- Requesters present operands with a level request. The arbiter picks one round-robin, launches the divider, and catches its done pulse.
- It then returns quotient and remainder to the winner, held until acknowledged.
- It intercepts divide-by-zero and guards against a hung divider with a timeout.

Parameters:
- N, 4, number of requesters (2..8)
- WIDTH, 24, operand width; must match the divider's WIDTH
- TIMEOUT, 64, max cycles in WAIT before aborting; must exceed WIDTH+2

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req  in  N  per-requester request level; held until grant
- req_sign  in  N  per-requester signed (1) / unsigned (0) select
- req_dividend  in  N*WIDTH  flattened dividends; requester i at [i*WIDTH +: WIDTH]
- req_divisor  in  N*WIDTH  flattened divisors, same packing
- grant  out  N  one-hot, one-cycle pulse: operands captured
- resp_valid  out  N  one-hot, high while a result is held for requester i
- resp_ack  in  N  requester i consumes the result; only meaningful while resp_valid[i]
- resp_quotient  out  WIDTH  result quotient
- resp_remainder  out  WIDTH  result remainder
- resp_dbz  out  1  result was divide-by-zero
- resp_err  out  1  result aborted by timeout
- busy  out  1  high in any state except IDLE
- div_start  out  1  one-cycle start pulse to divider
- div_sign  out  1  registered sign to divider
- div_dividend  out  WIDTH  registered dividend to divider
- div_divisor  out  WIDTH  registered divisor to divider
- div_quotient  in  WIDTH  divider quotient
- div_remainder  in  WIDTH  divider remainder
- div_ready  in  1  divider one-cycle done pulse, arriving WIDTH+1 cycles after div_start

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE, round-robin pointer ptr=0.
  - All outputs 0, including div_* operands and resp_* data.
- States: IDLE, LAUNCH, WAIT, RESP.
- IDLE:
  - If req!=0, select winner w = first set bit of req searching from ptr upward, wrapping modulo N.
  - Register w, sign, dividend and divisor into div_*; set dbz = (divisor==0). Go to LAUNCH.
- LAUNCH (exactly 1 cycle):
  - grant[w]=1.
  - If !dbz: div_start=1, clear timeout counter, go to WAIT.
  - If dbz: div_start stays 0; load quotient = all ones, remainder = captured dividend, resp_dbz=1; go to RESP.
  - ptr <= (w+1) mod N in both cases.
- WAIT:
  - Timeout counter increments every cycle.
  - On div_ready: capture div_quotient and div_remainder, resp_err=0, go to RESP.
  - If the counter reaches TIMEOUT-1 without div_ready: quotient=0, remainder=0, resp_err=1, go to RESP.
  - div_ready and timeout in the same cycle: div_ready wins.
- RESP:
  - resp_valid[w]=1 with data stable.
  - On resp_ack[w]: next cycle resp_valid=0, resp_dbz/resp_err cleared, go to IDLE.
  - resp_ack on other bits is ignored.
- div_ready outside WAIT is ignored, e.g. a stale pulse after reset or after a timeout.
- Latency:
  - req sampled in IDLE at cycle 0; grant and div_start at cycle 1.
  - resp_valid at cycle WIDTH+3 for a nominal divider, or cycle 2 for dbz.
- Back-to-back: a request pending in the cycle resp_ack is seen is arbitrated in the following IDLE cycle, so there is a minimum 1 idle cycle between jobs.
- Fairness: any continuously asserted req is granted within N jobs.
- Requester dropping req before grant is illegal. The arbiter still completes the job captured in IDLE.
- Operands on req_* are don't-care except in the IDLE sample cycle.
- Reset mid-operation: immediate return to reset state. The divider may still be running; its later div_ready is ignored because the state is not WAIT.
- busy = (state!=IDLE).

Test Plan:
- Single job: N=4, WIDTH=24; req[2] with 100/7 unsigned -> grant[2] at cycle 1, div_start at cycle 1; resp_valid[2] with quotient 14, remainder 2, dbz=0, err=0; cleared one cycle after resp_ack[2].
- Signed job: req[0] with -100/7, sign=1 -> quotient 0xFFFFF2 (-14), remainder 0xFFFFFE (-2).
- Round-robin: req=4'b1111 held, ack each result immediately -> grant order 0,1,2,3,0; then with ptr=1 and req=4'b0001 -> grant[0].
- Divide by zero: req[1] with 55/0 -> grant[1], no div_start, resp_valid[1] at cycle 2 with quotient 0xFFFFFF, remainder 55, resp_dbz=1.
- Timeout: divider model never pulses div_ready, TIMEOUT=64 -> resp_err=1, quotient and remainder 0, resp_valid exactly 64 cycles after leaving LAUNCH. A late div_ready pulse in RESP or IDLE changes nothing.
- Reset mid-WAIT: assert rst_n=0 at cycle 10 of a job -> all outputs 0 asynchronously, busy=0. The divider's pulse after reset release is ignored, and the next req[3] is granted normally with ptr=0 search.
